// File: rtl/pc_sequencer.sv
// Program-counter owner: registered PC, return-address stack and halt state.
// Every flow-control request lands on the next rising edge of clk.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 8,
  parameter logic [15:0] RET_OFFSET  = 16'd1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cnt_en,
  input  logic                           pc_sload,
  input  logic [15:0]                    new_pc,
  input  logic                           call,
  input  logic                           rtn,
  input  logic                           stop,
  input  logic                           resume,
  output logic [15:0]                    pc,
  output logic                           halted,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_err
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]     state, state_d;
  logic [15:0]    pc_d;
  logic [SPW-1:0] sp_d;
  logic           err_d;
  logic           push;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  wr_idx;
  logic [15:0]    stack_q [STACK_DEPTH];

  assign rd_idx = AW'(sp - SPW'(1));
  assign wr_idx = AW'(sp);
  assign halted = (state == HALT);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    sp_d    = sp;
    err_d   = stack_err;
    push    = 1'b0;
    if (state == RUN) begin
      priority case (1'b1)
        stop: state_d = HALT;
        call && rtn: begin
          err_d   = 1'b1;
          state_d = HALT;
        end
        rtn: begin
          if (sp == '0) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = stack_q[rd_idx];
            sp_d = sp - SPW'(1);
          end
        end
        call && pc_sload: begin
          if (sp == SPW'(STACK_DEPTH)) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            push = 1'b1;
            sp_d = sp + SPW'(1);
            pc_d = new_pc;
          end
        end
        pc_sload: pc_d = new_pc;
        cnt_en:   pc_d = pc + 16'd1;
        default: ;
      endcase
    end else if (resume && !stack_err) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      sp        <= sp_d;
      stack_err <= err_d;
    end
  end

  // Stack storage needs no reset; occupancy is tracked by sp alone.
  always_ff @(posedge clk) begin
    if (!reset && push) stack_q[wr_idx] <= pc + RET_OFFSET;
  end

endmodule
